adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 93 +++++++++
 tb/tb_adder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// adder -- registered signed add/subtract unit with overflow and carry flags.
//
// Purpose:
//   Computes A+B (sub=0) or A-B (sub=1) on two's-complement operands.
//   The result and flags are registered with a latency of exactly one cycle.
//   Subtraction is performed as A + ~B + 1, so carry_out is the true carry
//   for add and the not-borrow for subtract.
//
// Configuration:
//   ADDER_SAT_EN  when defined, an overflowing result saturates to the most
//                 positive or most negative value. When undefined, the
//                 result wraps around. Both builds have identical ports.
//
// Parameters:
//   WORD_WIDTH    operand and result width in bits (legal range 2..64).
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid this cycle
//   sub        in   0 = A+B, 1 = A-B (sampled with in_valid)
//   A, B       in   signed operands, WORD_WIDTH bits
//   out        out  registered signed result, WORD_WIDTH bits
//   out_valid  out  out holds a new result this cycle
//   ovf        out  signed overflow of the registered operation
//   carry_out  out  unsigned carry (add) / not-borrow (sub)
module adder #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  sub,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  output logic [WORD_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  ovf,
  output logic                  carry_out
);

  localparam int W = WORD_WIDTH;

  logic [W-1:0] b_eff;
  logic [W:0]   sum_full;
  logic [W-1:0] sum_wrap;
  logic         ovf_next;
  logic         carry_next;
  logic [W-1:0] res_next;

`ifdef ADDER_SAT_EN
  localparam logic [W-1:0] MaxPos = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};
`endif

  // Effective addition: subtraction inverts B and injects a carry-in of 1.
  // The sum is formed one bit wider so the top bit is the unsigned carry.
  always_comb begin
    b_eff      = sub ? ~B : B;
    sum_full   = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    sum_wrap   = sum_full[W-1:0];
    carry_next = sum_full[W];
    // Overflow: both addends share a sign and the result sign differs.
    ovf_next   = (A[W-1] == b_eff[W-1]) && (sum_wrap[W-1] != A[W-1]);
    res_next   = sum_wrap;
`ifdef ADDER_SAT_EN
    // On overflow the true result lies beyond the range in the direction
    // of the (shared) operand sign, so A's sign picks the clamp value.
    if (ovf_next) begin
      res_next = A[W-1] ? MinNeg : MaxPos;
    end
`endif
  end

  // Result and flag registers. Data only updates on a valid cycle and holds
  // otherwise; out_valid simply follows in_valid by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      ovf       <= 1'b0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out       <= res_next;
        ovf       <= ovf_next;
        carry_out <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// tb_adder -- self-checking bench for adder (WORD_WIDTH=16).
//
// Directed vectors cover the worked examples and most-negative corner
// cases, an asynchronous mid-cycle reset, then a randomized run compared
// against an arithmetic reference model using exact integer math.
module tb_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] dout;
  logic         out_valid;
  logic         ovf;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0] m_out;
  logic         m_ovf;
  logic         m_carry;
  logic         m_valid;

  adder #(.WORD_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sub       (sub),
    .A         (op_a),
    .B         (op_b),
    .out       (dout),
    .out_valid (out_valid),
    .ovf       (ovf),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Exact-integer reference: compute the mathematical result, then derive
  // wrap, overflow (out of signed range) and carry (unsigned range).
  task automatic model(input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] r,
                       output logic o, output logic c);
    longint sa, sb, ua, ub, exact, lim;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    ua    = longint'(a);
    ub    = longint'(b);
    lim   = longint'(1) <<< (W - 1);
    exact = s ? (sa - sb) : (sa + sb);
    o     = (exact >= lim) || (exact < -lim);
    r     = exact[W-1:0];
`ifdef ADDER_SAT_EN
    if (o) r = (exact >= lim) ? W'(lim - 1) : W'(-lim);
`endif
    c = s ? (ua >= ub) : ((ua + ub) >= (lim * 2));
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    checkOutput({tag, "_out"},   64'(dout),      64'(m_out));
    checkOutput({tag, "_ovf"},   64'(ovf),       64'(m_ovf));
    checkOutput({tag, "_carry"}, 64'(carry_out), 64'(m_carry));
  endtask

  // Drive one cycle of inputs at a falling edge, advance to the next
  // falling edge, update the model and compare everything.
  task automatic applyStimulus(input logic v, input logic s,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input string tag);
    logic [W-1:0] r;
    logic o, c;
    in_valid = v;
    sub      = s;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    m_valid = v;
    if (v) begin
      model(s, a, b, r, o, c);
      m_out   = r;
      m_ovf   = o;
      m_carry = c;
    end
    checkAll(tag);
  endtask

  function automatic logic [W-1:0] pickOperand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = {1'b0, {(W-1){1'b1}}};
      1: v = {1'b1, {(W-1){1'b0}}};
      2: v = '1;
      3: v = '0;
      4: v = W'(1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sub      = 1'b0;
    op_a     = '0;
    op_b     = '0;
    m_out    = '0;
    m_ovf    = 1'b0;
    m_carry  = 1'b0;
    m_valid  = 1'b0;

    #2;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Worked examples with literal expectations.
    applyStimulus(1'b1, 1'b0, 16'd156, 16'd12, "add1");
    checkOutput("ex_add1", 64'(dout), 64'd168);
    applyStimulus(1'b1, 1'b0, 16'd148, 16'd45, "add2");
    checkOutput("ex_add2", 64'(dout), 64'd193);
    applyStimulus(1'b0, 1'b0, 16'd1, 16'd1, "hold");
    checkOutput("ex_hold", 64'(dout), 64'd193);
    applyStimulus(1'b1, 1'b1, 16'd12, 16'd156, "sub1");
    checkOutput("ex_sub1", 64'(dout), 64'(16'hFF70));
    applyStimulus(1'b1, 1'b1, 16'd156, 16'd12, "sub2");
    checkOutput("ex_sub2_carry", 64'(carry_out), 64'd1);
    applyStimulus(1'b1, 1'b0, 16'h7FFF, 16'h0001, "posovf");
`ifdef ADDER_SAT_EN
    checkOutput("ex_posovf", 64'(dout), 64'(16'h7FFF));
`else
    checkOutput("ex_posovf", 64'(dout), 64'(16'h8000));
`endif
    applyStimulus(1'b1, 1'b0, 16'h8000, 16'hFFFF, "negovf");
`ifdef ADDER_SAT_EN
    checkOutput("ex_negovf", 64'(dout), 64'(16'h8000));
`else
    checkOutput("ex_negovf", 64'(dout), 64'(16'h7FFF));
`endif
    checkOutput("ex_negovf_carry", 64'(carry_out), 64'd1);
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h8000, "zeromin");
    checkOutput("ex_zeromin_ovf", 64'(ovf), 64'd1);

    // Asynchronous reset in the middle of a cycle after a valid result.
    applyStimulus(1'b1, 1'b0, 16'd100, 16'd23, "prerst");
    #2;
    rst_n = 1'b0;
    #1;
    m_out = '0; m_ovf = 1'b0; m_carry = 1'b0; m_valid = 1'b0;
    checkAll("asyncrst");
    in_valid = 1'b1;
    op_a     = 16'd7;
    op_b     = 16'd9;
    @(negedge clk);
    checkAll("inrst");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checkAll("postrst");
    applyStimulus(1'b1, 1'b0, 16'd7, 16'd9, "firstpost");

    // Randomized run, including back-to-back valid cycles.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    pickOperand(), pickOperand(), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
